mp_expr_fifo_stage: RTL and testbench

//   Buffered valid/ready stage placed upstream of modport-expression consumers.
//   Its ports bind through modport expression aliases (e.g. .in(sig_a), .out(sig_b)).
//   It accepts words from a producer, holds up to DEPTH of them in a first-word-fall-through
//   (FWFT) FIFO, and presents them to the downstream consumer.
//   It also keeps a running XOR checksum of the delivered words, so a bench can compare
//   end-to-end integrity against an xor-reducing consumer.

---
 rtl/mp_expr_fifo_stage.sv | 100 ++++++++++
 tb/tb_mp_expr_fifo_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mp_expr_fifo_stage.sv
// Purpose : buffered valid/ready stage, DEPTH-word first-word-fall-through FIFO
//           with a running XOR checksum of every word delivered downstream.
// Latency : one cycle from push into an empty FIFO to out_valid/out_data.
// Backpr. : in_ready = (count < DEPTH) from registered state only; a pop while
//           full frees the slot but in_ready rises only in the next cycle.
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   in_valid/in_ready    producer handshake, in_data is the offered word
//   out_valid/out_ready  consumer handshake, out_data is the head word (0 when empty)
//   count                number of stored words, 0..DEPTH
//   xsum                 XOR of every word popped since reset
module mp_expr_fifo_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           xsum
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage is deliberately left out of reset; only valid entries are ever read.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] xsum_q,   xsum_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_dat;

  // Both handshake qualifiers come from registered state, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign head_dat  = mem_q[rd_ptr_q];
  assign out_data  = out_valid ? head_dat : '0;
  assign count     = count_q;
  assign xsum      = xsum_q;

  // Reset wins over both transfers in the same cycle.
  assign push = in_valid  & in_ready  & ~rst;
  assign pop  = out_valid & out_ready & ~rst;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    xsum_d   = xsum_q;

    // Pointers are exactly AW bits wide, so DEPTH-1 + 1 wraps to 0 by itself.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      xsum_d   = xsum_q ^ head_dat;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      xsum_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      xsum_q   <= xsum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_mp_expr_fifo_stage.sv
module tb_mp_expr_fifo_stage;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] xsum;

  int tests_run = 0;
  int tests_failed = 0;

  mp_expr_fifo_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .xsum      (xsum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the running checksum.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] mxsum;
  bit               model_live = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mxsum      = '0;
      model_live = 1;
    end else if (model_live) begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() > 0);
      if (do_pop) begin
        mxsum = mxsum ^ mq[0];
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back(in_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      logic [WIDTH-1:0] exp_head;
      exp_head = (mq.size() > 0) ? mq[0] : '0;
      check("cmp_count",     32'(count),     32'(mq.size()));
      check("cmp_in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
      check("cmp_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("cmp_out_data",  32'(out_data),  32'(exp_head));
      check("cmp_xsum",      32'(xsum),      32'(mxsum));
    end
  end

  // Advance one clock; inputs change and literal checks happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] t3_words [4];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;

    // T1 reset
    do_reset(2);
    check("t1_count",     32'(count),     32'd0);
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_out_data",  32'(out_data),  32'd0);
    check("t1_xsum",      32'(xsum),      32'd0);
    check("t1_in_ready",  32'(in_ready),  32'd1);

    // T2 latency: visible one cycle after the push, not before
    in_valid = 1'b1;
    in_data  = 8'h42;
    #2;
    check("t2_no_passthru", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_out_data",  32'(out_data),  32'h42);
    check("t2_count",     32'(count),     32'd1);
    do_reset(1);

    // T3 fill to full, then offer a fifth word
    t3_words[0] = 8'hF0;
    t3_words[1] = 8'h0F;
    t3_words[2] = 8'hAB;
    t3_words[3] = 8'hCD;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = t3_words[i];
      step();
    end
    check("t3_count_full", 32'(count),    32'd4);
    check("t3_in_ready",   32'(in_ready), 32'd0);
    in_data = 8'h99;
    step();
    in_valid = 1'b0;
    check("t3_count_held", 32'(count),    32'd4);
    check("t3_head",       32'(out_data), 32'hF0);

    // T4 drain and checksum
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_out_data_%0d", i), 32'(out_data), 32'(t3_words[i]));
      step();
    end
    out_ready = 1'b0;
    check("t4_xsum",      32'(xsum),      32'h99);
    check("t4_count",     32'(count),     32'd0);
    check("t4_out_valid", 32'(out_valid), 32'd0);
    do_reset(1);

    // T5 streaming 1..10 with both sides always ready
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_data = 8'(k);
      step();
      check($sformatf("t5_count_%0d", k),    32'(count),    32'd1);
      check($sformatf("t5_out_data_%0d", k), 32'(out_data), 32'(k));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("t5_xsum",  32'(xsum),  32'h0B);
    check("t5_count", 32'(count), 32'd0);

    // T6 reset mid-stream with count=3
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + i);
      step();
    end
    check("t6_count_pre", 32'(count), 32'd3);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 8'h77;
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t6_count",     32'(count),     32'd0);
    check("t6_xsum",      32'(xsum),      32'd0);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    step();
    check("t6_not_stored", 32'(count),    32'd0);

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_data   = 8'($urandom);
      step();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    check("drain_empty", 32'(out_valid), 32'd0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
